string_op_engine: RTL and testbench

Sequential string-processing engine that sits directly downstream of the Avalon string register block. It consumes the StringA/StringB word arrays and the control fields that block holds. It walks the strings one byte per cycle and performs strcmp, strlen or strchr. It returns a 32-bit result with a busy/done handshake for the Control/Status and Result registers.

---
 rtl/string_op_engine.sv | 136 +++++++++++++
 tb/tb_string_op_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/string_op_engine.sv
// string_op_engine: walks StringA (and StringB) one byte per cycle to compute
// strcmp, strlen or strchr. Inputs are read live while busy; result is
// registered on entry to DONE and held until the next completion.
module string_op_engine #(
   parameter int unsigned MAX_WORDS = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   go,
   input  logic [1:0]             opcode,
   input  logic [7:0]             char_in,
   input  logic [32*MAX_WORDS-1:0] string_a,
   input  logic [32*MAX_WORDS-1:0] string_b,
   output logic                   busy,
   output logic                   done,
   output logic [31:0]            result
);

   localparam int unsigned N  = 4 * MAX_WORDS;
   localparam int unsigned IW = $clog2(N) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t        state_q;
   logic [IW-1:0] idx_q;
   logic          busy_q;
   logic          done_q;
   logic [31:0]   result_q;

   logic [7:0]    a_byte;
   logic [7:0]    b_byte;
   logic          last_byte;
   logic [8:0]    diff;
   logic          term_d;
   logic [31:0]   result_d;

   // Select byte idx of each string (little-endian byte packing within words)
   always_comb begin
      a_byte = '0;
      b_byte = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (idx_q == k[IW-1:0]) begin
            a_byte = string_a[8*k +: 8];
            b_byte = string_b[8*k +: 8];
         end
      end
   end

   // Decide whether the current byte ends the operation, and with what result
   always_comb begin
      last_byte = (idx_q == IW'(N - 1));
      diff      = {1'b0, a_byte} - {1'b0, b_byte};
      term_d    = 1'b0;
      result_d  = '0;
      case (opcode)
         2'd0: begin
            if (a_byte != b_byte) begin
               term_d   = 1'b1;
               result_d = {{23{diff[8]}}, diff};
            end else if (a_byte == 8'h00 || last_byte) begin
               term_d   = 1'b1;
               result_d = '0;
            end
         end
         2'd1: begin
            if (a_byte == 8'h00) begin
               term_d   = 1'b1;
               result_d = 32'(idx_q);
            end else if (last_byte) begin
               term_d   = 1'b1;
               result_d = 32'(N);
            end
         end
         2'd2: begin
            // A match is tested first so char_in = 0 finds the terminator
            if (a_byte == char_in) begin
               term_d   = 1'b1;
               result_d = 32'(idx_q);
            end else if (a_byte == 8'h00 || last_byte) begin
               term_d   = 1'b1;
               result_d = '1;
            end
         end
         default: begin
            term_d   = 1'b1;
            result_d = '1;
         end
      endcase
   end

   // Control FSM with registered busy/done/result
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (go) begin
                  state_q <= S_RUN;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            S_RUN: begin
               if (term_d) begin
                  state_q  <= S_DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  result_q <= result_d;
               end else begin
                  idx_q <= idx_q + IW'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_string_op_engine.sv
// Bench for string_op_engine: directed vector table, handshake/reset corner
// sequences, and randomized operations against a byte-array reference model.
module tb_string_op_engine;

   localparam int unsigned MW = 8;
   localparam int unsigned N  = 4 * MW;

   logic            clk = 1'b0;
   logic            reset;
   logic            go;
   logic [1:0]      opcode;
   logic [7:0]      char_in;
   logic [32*MW-1:0] string_a;
   logic [32*MW-1:0] string_b;
   logic            busy;
   logic            done;
   logic [31:0]     result;

   int n_pass  = 0;
   int n_total = 0;

   string_op_engine #(.MAX_WORDS(MW)) dut (
      .clk      (clk),
      .reset    (reset),
      .go       (go),
      .opcode   (opcode),
      .char_in  (char_in),
      .string_a (string_a),
      .string_b (string_b),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   op;
      logic [7:0]   ch;
      logic [255:0] a;
      logic [255:0] b;
      logic [31:0]  exp_res;
      int           exp_lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, got, exp);
   endtask

   function automatic logic [255:0] mk(input string s);
      logic [255:0] v;
      v = '0;
      for (int i = 0; i < s.len(); i++) v[8*i +: 8] = s[i];
      return v;
   endfunction

   // Reference: C-style string semantics over byte arrays; k = terminating byte
   function automatic void model(input logic [1:0] op, input logic [7:0] ch,
                                 input logic [255:0] a, input logic [255:0] b,
                                 output logic [31:0] res, output int k);
      byte unsigned av[N];
      byte unsigned bv[N];
      for (int i = 0; i < N; i++) begin
         av[i] = a[8*i +: 8];
         bv[i] = b[8*i +: 8];
      end
      case (op)
         2'd0: begin
            res = 0; k = N - 1;
            for (int i = 0; i < N; i++) begin
               if (av[i] != bv[i]) begin
                  res = 32'(int'(av[i]) - int'(bv[i])); k = i; break;
               end else if (av[i] == 0) begin
                  k = i; break;
               end
            end
         end
         2'd1: begin
            res = N; k = N - 1;
            for (int i = 0; i < N; i++)
               if (av[i] == 0) begin res = i; k = i; break; end
         end
         2'd2: begin
            res = '1; k = N - 1;
            for (int i = 0; i < N; i++) begin
               if (av[i] == ch) begin res = i; k = i; break; end
               else if (av[i] == 0) begin k = i; break; end
            end
         end
         default: begin res = '1; k = 0; end
      endcase
   endfunction

   // Pulse go in cycle c; count cycles until done. repulse>0 re-asserts go in
   // cycle c+repulse. busy_ok reports busy=1/done=0 throughout RUN.
   task automatic do_op(input logic [1:0] op, input logic [7:0] ch,
                        input logic [255:0] a, input logic [255:0] b,
                        input int repulse,
                        output logic [31:0] res, output int lat,
                        output logic busy_ok, output logic done_c1,
                        output logic [31:0] res_c1);
      int cyc;
      @(negedge clk);
      opcode = op; char_in = ch; string_a = a; string_b = b; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      cyc = 1;
      busy_ok = 1'b1;
      done_c1 = done;
      res_c1 = result;
      while (done !== 1'b1 && cyc < 100) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         go = (cyc == repulse);
         @(negedge clk);
         cyc++;
      end
      go = 1'b0;
      if (busy !== 1'b0) busy_ok = 1'b0;
      res = result;
      lat = cyc;
   endtask

   logic [255:0] full_a, full_b, abc, ten;
   logic [31:0]  r, r_c1, m_res, prev;
   int           lat, mk_k;
   logic         bok, d_c1;

   initial begin
      reset = 1'b0; go = 1'b0; opcode = '0; char_in = '0;
      string_a = '0; string_b = '0;
      repeat (3) @(negedge clk);
      check("reset_busy",   32'(busy),   32'd0);
      check("reset_done",   32'(done),   32'd0);
      check("reset_result", result,      32'd0);
      reset = 1'b1;

      full_a = '0;
      for (int i = 0; i < N; i++) full_a[8*i +: 8] = 8'h41 + 8'(i);
      full_b = full_a;
      full_b[255:248] = full_a[255:248] + 8'd1;
      abc = mk("abc");

      vecs.push_back('{2'd1, 8'h00, abc,           '0,           32'd3,          5});
      vecs.push_back('{2'd0, 8'h00, abc,           mk("abd"),    32'hFFFF_FFFF,  4});
      vecs.push_back('{2'd0, 8'h00, mk("abd"),     abc,          32'd1,          4});
      vecs.push_back('{2'd0, 8'h00, mk("hi"),      mk("hi"),     32'd0,          4});
      vecs.push_back('{2'd2, 8'h63, mk("abcabc"),  '0,           32'd2,          4});
      vecs.push_back('{2'd2, 8'h7A, mk("abcabc"),  '0,           32'hFFFF_FFFF,  8});
      vecs.push_back('{2'd2, 8'h00, mk("abcabc"),  '0,           32'd6,          8});
      vecs.push_back('{2'd1, 8'h00, full_a,        '0,           32'd32,        33});
      vecs.push_back('{2'd0, 8'h00, full_a,        full_a,       32'd0,         33});
      vecs.push_back('{2'd0, 8'h00, full_a,        full_b,       32'hFFFF_FFFF, 33});
      vecs.push_back('{2'd2, 8'h60, full_a,        '0,           32'd31,        33});
      vecs.push_back('{2'd2, 8'h7E, full_a,        '0,           32'hFFFF_FFFF, 33});
      vecs.push_back('{2'd3, 8'h00, abc,           abc,          32'hFFFF_FFFF,  2});
      vecs.push_back('{2'd1, 8'h00, '0,            '0,           32'd0,          2});
      vecs.push_back('{2'd0, 8'h00, mk("\377"),    mk("\001"),   32'h0000_00FE,  2});
      vecs.push_back('{2'd0, 8'h00, mk("\001"),    mk("\377"),   32'hFFFF_FF02,  2});

      foreach (vecs[i]) begin
         do_op(vecs[i].op, vecs[i].ch, vecs[i].a, vecs[i].b, 0, r, lat, bok, d_c1, r_c1);
         check($sformatf("vec%0d_result", i), r, vecs[i].exp_res);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         check($sformatf("vec%0d_busy", i), 32'(bok), 32'd1);
      end

      // go while busy is ignored; latency unchanged
      do_op(2'd1, 8'h00, abc, '0, 2, r, lat, bok, d_c1, r_c1);
      check("rego_result",  r,          32'd3);
      check("rego_latency", 32'(lat),   32'd5);
      check("rego_busy",    32'(bok),   32'd1);

      // go from DONE: done drops next cycle, result holds through RUN
      prev = result;
      do_op(2'd0, 8'h00, abc, mk("abd"), 0, r, lat, bok, d_c1, r_c1);
      check("done_drop",     32'(d_c1), 32'd0);
      check("result_hold",   r_c1,      prev);
      check("next_result",   r,         32'hFFFF_FFFF);
      check("next_latency",  32'(lat),  32'd4);

      // reset asserted mid-RUN in cycle c+3
      ten = mk("abcdefghij");
      @(negedge clk);
      opcode = 2'd1; string_a = ten; go = 1'b1;
      @(negedge clk); go = 1'b0;
      @(negedge clk);
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      check("rst_busy",   32'(busy), 32'd0);
      check("rst_done",   32'(done), 32'd0);
      check("rst_result", result,    32'd0);
      reset = 1'b1;
      do_op(2'd1, 8'h00, ten, '0, 0, r, lat, bok, d_c1, r_c1);
      check("post_rst_result",  r,        32'd10);
      check("post_rst_latency", 32'(lat), 32'd12);

      // randomized operations against the reference model
      for (int t = 0; t < 40; t++) begin
         logic [255:0] ra, rb;
         logic [1:0]   rop;
         logic [7:0]   rch;
         int           len;
         len = $urandom_range(0, N);
         for (int i = 0; i < N; i++)
            ra[8*i +: 8] = (i == len) ? 8'h00 : 8'h61 + 8'($urandom_range(0, 3));
         rb = ra;
         if ($urandom_range(0, 1) == 1)
            rb[8*$urandom_range(0, N-1) +: 8] = 8'($urandom_range(0, 255));
         rop = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       rch = 8'h00;
            1:       rch = 8'h7A;
            default: rch = 8'h61 + 8'($urandom_range(0, 3));
         endcase
         model(rop, rch, ra, rb, m_res, mk_k);
         do_op(rop, rch, ra, rb, 0, r, lat, bok, d_c1, r_c1);
         check($sformatf("rand%0d_result", t),  r,        m_res);
         check($sformatf("rand%0d_latency", t), 32'(lat), 32'(mk_k + 2));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
      $fatal(1);
   end

endmodule
